// File: rtl/cmac_seq_pkg.sv
// cmac_link_sequencer shared types: state encodings,
// FEC mode codes, counter widths and small helpers.
package cmac_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_DP   = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_QUALIFY    = 3'd3,
    ST_LINKED     = 3'd4
  } seq_state_e;

  localparam logic [1:0] FEC_OFF  = 2'd0;
  localparam logic [1:0] FEC_ON   = 2'd1;
  localparam logic [1:0] FEC_AUTO = 2'd2;

  localparam int CNT_W = 16;
  localparam int TMR_W = 32;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Auto mode starts each mode change with FEC on.
  function automatic logic fec_start(
    input logic [1:0] m
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      m == FEC_ON:   r = 1'b1;
      m >= FEC_AUTO: r = 1'b1;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_auto(
    input logic [1:0] m
  );
    return m >= FEC_AUTO;
  endfunction

endpackage

// File: rtl/cmac_seq_timer.sv
// Loadable 32-bit down-counter. done marks the last cycle
// of a loaded interval; a load of 0 behaves like a load of 1.
module cmac_seq_timer
  import cmac_seq_pkg::*;
(
  input  logic             rx_clk,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge rx_clk) begin
    if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TMR_W'(1);
    end
  end

  assign done = (count <= TMR_W'(1));

endmodule

// File: rtl/cmac_link_sequencer.sv
// CMAC RX bring-up sequencer with RS-FEC auto toggling.
// Define CMAC_SEQ_LATENCY_EN to build the align_latency counter.
module cmac_link_sequencer
  import cmac_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 50,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned ALIGN_TIMEOUT = 644531250,
  parameter int unsigned STABLE_CYCLES = 4096
) (
  input  logic             rx_clk,
  input  logic             rx_reset,
  input  logic [1:0]       fec_mode_cfg,
  input  logic             stat_rx_aligned,
  output logic             ctl_rsfec_enable,
  output logic             reset_rx_datapath,
  output logic             ctl_tx_enable,
  output logic             ctl_tx_send_rfi,
  output logic             link_up,
  output logic [CNT_W-1:0] attempt_count,
  output logic [CNT_W-1:0] link_drop_count,
  output logic [2:0]       seq_state,
  output logic [31:0]      align_latency
);

  localparam logic [TMR_W-1:0] T_RST = TMR_W'(RESET_CYCLES);
  localparam logic [TMR_W-1:0] T_SET = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] T_ALN = TMR_W'(ALIGN_TIMEOUT);
  localparam logic [TMR_W-1:0] T_STB = TMR_W'(STABLE_CYCLES);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [1:0]       cfg_q;
  logic             fec_q;
  logic             fec_d;
  logic             cfg_chg;
  logic             ph_load;
  logic [TMR_W-1:0] ph_val;
  logic             ph_done;
  logic             al_load;
  logic             al_done;
  logic             att_inc;
  logic             drop_inc;
  logic             rdp_d;
  logic             link_d;

  assign cfg_chg = (fec_mode_cfg != cfg_q);

  cmac_seq_timer u_phase (
    .rx_clk   (rx_clk),
    .load     (rx_reset | ph_load),
    .load_val (rx_reset ? T_RST : ph_val),
    .done     (ph_done)
  );

  cmac_seq_timer u_align (
    .rx_clk   (rx_clk),
    .load     (rx_reset | al_load),
    .load_val (T_ALN),
    .done     (al_done)
  );

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q <= ST_RESET_DP;
      cfg_q   <= fec_mode_cfg;
      fec_q   <= fec_start(fec_mode_cfg);
    end else begin
      state_q <= state_d;
      cfg_q   <= fec_mode_cfg;
      fec_q   <= fec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fec_d    = fec_q;
    ph_load  = 1'b0;
    ph_val   = T_RST;
    al_load  = 1'b0;
    att_inc  = 1'b0;
    drop_inc = 1'b0;
    if (cfg_chg) begin
      state_d = ST_RESET_DP;
      fec_d   = fec_start(fec_mode_cfg);
      ph_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_RESET_DP: begin
          if (ph_done) begin
            state_d = ST_SETTLE;
            ph_load = 1'b1;
            ph_val  = T_SET;
          end
        end
        ST_SETTLE: begin
          if (ph_done) begin
            state_d = ST_WAIT_ALIGN;
            al_load = 1'b1;
            att_inc = 1'b1;
          end
        end
        ST_WAIT_ALIGN: begin
          if (stat_rx_aligned) begin
            state_d = ST_QUALIFY;
            ph_load = 1'b1;
            ph_val  = T_STB;
          end else if (al_done) begin
            state_d = ST_RESET_DP;
            ph_load = 1'b1;
            fec_d   = is_auto(cfg_q) ? ~fec_q : fec_q;
          end
        end
        ST_QUALIFY: begin
          if (!stat_rx_aligned) begin
            state_d = ST_WAIT_ALIGN;
          end else if (ph_done) begin
            state_d = ST_LINKED;
          end else if (al_done) begin
            state_d = ST_RESET_DP;
            ph_load = 1'b1;
            fec_d   = is_auto(cfg_q) ? ~fec_q : fec_q;
          end
        end
        ST_LINKED: begin
          // FEC is kept so the last-good mode is retried first.
          if (!stat_rx_aligned) begin
            state_d  = ST_RESET_DP;
            ph_load  = 1'b1;
            drop_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_RESET_DP;
          ph_load = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rdp_d  = (state_d == ST_RESET_DP);
    link_d = (state_d == ST_LINKED);
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      reset_rx_datapath <= 1'b1;
      link_up           <= 1'b0;
      ctl_tx_enable     <= 1'b0;
      ctl_tx_send_rfi   <= 1'b1;
      attempt_count     <= '0;
      link_drop_count   <= '0;
    end else begin
      reset_rx_datapath <= rdp_d;
      link_up           <= link_d;
      ctl_tx_enable     <= link_d;
      ctl_tx_send_rfi   <= ~link_d;
      if (att_inc) begin
        attempt_count <= sat_inc(attempt_count);
      end
      if (drop_inc) begin
        link_drop_count <= sat_inc(link_drop_count);
      end
    end
  end

  assign ctl_rsfec_enable = fec_q;
  assign seq_state        = state_q;

`ifdef CMAC_SEQ_LATENCY_EN
  logic [31:0] lat_cnt;
  logic [31:0] lat_q;
  logic        in_align;

  assign in_align = (state_q == ST_WAIT_ALIGN) ||
                    (state_q == ST_QUALIFY);

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      lat_cnt <= '0;
      lat_q   <= '0;
    end else begin
      if (att_inc) begin
        lat_cnt <= '0;
      end else if (in_align) begin
        lat_cnt <= lat_cnt + 32'd1;
      end
      // Include the cycle on which LINKED is entered.
      if (link_d && state_q == ST_QUALIFY) begin
        lat_q <= lat_cnt + 32'd1;
      end
    end
  end

  assign align_latency = lat_q;
`else
  assign align_latency = '0;
`endif

endmodule

// File: tb/tb_cmac_link_sequencer.sv
// Scoreboard bench for cmac_link_sequencer: phase-age model
// predicts every cycle's outputs; monitor compares on negedge.
module tb_cmac_link_sequencer;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int AT = 100;
  localparam int QC = 16;

  localparam int P_RST  = 0;
  localparam int P_SET  = 1;
  localparam int P_WAIT = 2;
  localparam int P_QUAL = 3;
  localparam int P_LINK = 4;

  logic        rx_clk = 1'b0;
  logic        rx_reset = 1'b1;
  logic [1:0]  fec_mode_cfg = 2'd2;
  logic        stat_rx_aligned = 1'b0;
  logic        ctl_rsfec_enable;
  logic        reset_rx_datapath;
  logic        ctl_tx_enable;
  logic        ctl_tx_send_rfi;
  logic        link_up;
  logic [15:0] attempt_count;
  logic [15:0] link_drop_count;
  logic [2:0]  seq_state;
  logic [31:0] align_latency;

  cmac_link_sequencer #(
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .ALIGN_TIMEOUT (AT),
    .STABLE_CYCLES (QC)
  ) dut (
    .rx_clk            (rx_clk),
    .rx_reset          (rx_reset),
    .fec_mode_cfg      (fec_mode_cfg),
    .stat_rx_aligned   (stat_rx_aligned),
    .ctl_rsfec_enable  (ctl_rsfec_enable),
    .reset_rx_datapath (reset_rx_datapath),
    .ctl_tx_enable     (ctl_tx_enable),
    .ctl_tx_send_rfi   (ctl_tx_send_rfi),
    .link_up           (link_up),
    .attempt_count     (attempt_count),
    .link_drop_count   (link_drop_count),
    .seq_state         (seq_state),
    .align_latency     (align_latency)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        rdp;
    logic        fec;
    logic        txen;
    logic        rfi;
    logic        link;
    logic [15:0] att;
    logic [15:0] drop;
    logic [31:0] lat;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_ph, m_age, m_wait, m_att, m_drop, m_lat;
  bit   m_fec;
  logic [1:0] m_cfg;

  function automatic int lim(int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Reference model: counts cycles spent per phase upward.
  always @(posedge rx_clk) begin
    obs_t e;
    if (rx_reset) begin
      m_ph = P_RST; m_age = 0; m_wait = 0;
      m_cfg = fec_mode_cfg; m_fec = (fec_mode_cfg != 0);
      m_att = 0; m_drop = 0; m_lat = 0;
    end else if (fec_mode_cfg != m_cfg) begin
      m_cfg = fec_mode_cfg;
      m_fec = (fec_mode_cfg != 0);
      m_ph = P_RST; m_age = 0;
    end else begin
      case (m_ph)
        P_RST: begin
          m_age++;
          if (m_age >= lim(RC)) begin
            m_ph = P_SET; m_age = 0;
          end
        end
        P_SET: begin
          m_age++;
          if (m_age >= lim(SC)) begin
            m_ph = P_WAIT; m_wait = 0;
            if (m_att < 65535) m_att++;
          end
        end
        P_WAIT: begin
          m_wait++;
          if (stat_rx_aligned) begin
            m_ph = P_QUAL; m_age = 0;
          end else if (m_wait >= lim(AT)) begin
            if (m_cfg >= 2) m_fec = !m_fec;
            m_ph = P_RST; m_age = 0;
          end
        end
        P_QUAL: begin
          m_wait++;
          m_age++;
          if (!stat_rx_aligned) begin
            m_ph = P_WAIT;
          end else if (m_age >= lim(QC)) begin
            m_ph = P_LINK; m_lat = m_wait;
          end else if (m_wait >= lim(AT)) begin
            if (m_cfg >= 2) m_fec = !m_fec;
            m_ph = P_RST; m_age = 0;
          end
        end
        default: begin
          if (!stat_rx_aligned) begin
            if (m_drop < 65535) m_drop++;
            m_ph = P_RST; m_age = 0;
          end
        end
      endcase
    end
    e.st   = 3'(m_ph);
    e.rdp  = (m_ph == P_RST);
    e.fec  = m_fec;
    e.link = (m_ph == P_LINK);
    e.txen = (m_ph == P_LINK);
    e.rfi  = (m_ph != P_LINK);
    e.att  = 16'(m_att);
    e.drop = 16'(m_drop);
`ifdef CMAC_SEQ_LATENCY_EN
    e.lat  = 32'(m_lat);
`else
    e.lat  = 32'd0;
`endif
    exp_q.push_back(e);
  end

  always @(negedge rx_clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = seq_state; a.rdp = reset_rx_datapath;
      a.fec = ctl_rsfec_enable; a.txen = ctl_tx_enable;
      a.rfi = ctl_tx_send_rfi; a.link = link_up;
      a.att = attempt_count; a.drop = link_drop_count;
      a.lat = align_latency;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got st=%0d rdp=%b fec=%b txen=%b rfi=%b link=%b att=%0d drop=%0d lat=%0d exp st=%0d rdp=%b fec=%b txen=%b rfi=%b link=%b att=%0d drop=%0d lat=%0d",
          $time, a.st, a.rdp, a.fec, a.txen, a.rfi, a.link,
          a.att, a.drop, a.lat, e.st, e.rdp, e.fec, e.txen,
          e.rfi, e.link, e.att, e.drop, e.lat);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rx_reset = 1'b1;
    tick(3);
    rx_reset = 1'b0;
  endtask

  initial begin
    // Bring-up with aligned first sampled on cycle 30.
    fec_mode_cfg = 2'd2;
    stat_rx_aligned = 1'b0;
    tick(2);
    chk("reset_rdp", 32'(reset_rx_datapath), 32'd1);
    chk("reset_rfi", 32'(ctl_tx_send_rfi), 32'd1);
    do_reset();
    tick(3);
    chk("rdp_cycle4", 32'(reset_rx_datapath), 32'd1);
    tick(1);
    chk("rdp_cycle5", 32'(reset_rx_datapath), 32'd0);
    tick(25);
    stat_rx_aligned = 1'b1;
    tick(16);
    chk("link_early", 32'(link_up), 32'd0);
    tick(1);
    chk("link_up", 32'(link_up), 32'd1);
    chk("attempts1", 32'(attempt_count), 32'd1);
    chk("fec_on", 32'(ctl_rsfec_enable), 32'd1);
    tick(20);

    // Drop in LINKED, then never align: repeated timeouts.
    stat_rx_aligned = 1'b0;
    tick(1);
    chk("drop_link", 32'(link_up), 32'd0);
    chk("drop_cnt", 32'(link_drop_count), 32'd1);
    chk("drop_fec", 32'(ctl_rsfec_enable), 32'd1);
    tick(3 * (RC + SC + AT) + 20);

    // Aligned toggling every 10 cycles never qualifies.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      stat_rx_aligned = ~stat_rx_aligned;
      tick(10);
    end

    // FEC forced off: link, then drop.
    fec_mode_cfg = 2'd0;
    stat_rx_aligned = 1'b0;
    tick(14);
    stat_rx_aligned = 1'b1;
    tick(40);
    chk("off_link", 32'(link_up), 32'd1);
    chk("off_fec", 32'(ctl_rsfec_enable), 32'd0);
    stat_rx_aligned = 1'b0;
    tick(1);
    chk("off_drop", 32'(link_drop_count), 32'd1);
    chk("off_drop_fec", 32'(ctl_rsfec_enable), 32'd0);
    chk("off_drop_rdp", 32'(reset_rx_datapath), 32'd1);

    // Mode change out of LINKED, then reset mid-SETTLE.
    fec_mode_cfg = 2'd2;
    tick(14);
    stat_rx_aligned = 1'b1;
    tick(40);
    chk("auto_link", 32'(link_up), 32'd1);
    fec_mode_cfg = 2'd0;
    tick(1);
    chk("chg_link", 32'(link_up), 32'd0);
    chk("chg_fec", 32'(ctl_rsfec_enable), 32'd0);
    chk("chg_drop", 32'(link_drop_count), 32'd1);
    tick(6);
    rx_reset = 1'b1;
    tick(1);
    rx_reset = 1'b0;
    chk("rst_state", 32'(seq_state), 32'd0);
    chk("rst_att", 32'(attempt_count), 32'd0);
    chk("rst_drop", 32'(link_drop_count), 32'd0);
    chk("rst_rdp", 32'(reset_rx_datapath), 32'd1);

    // Latency: aligned on the 20th WAIT_ALIGN cycle.
    fec_mode_cfg = 2'd2;
    stat_rx_aligned = 1'b0;
    do_reset();
    tick(31);
    stat_rx_aligned = 1'b1;
    tick(17);
    chk("lat_link", 32'(link_up), 32'd1);
`ifdef CMAC_SEQ_LATENCY_EN
    chk("lat_value", align_latency, 32'd36);
`else
    chk("lat_value", align_latency, 32'd0);
`endif

    // Randomized alignment, mode changes and resets.
    for (int i = 0; i < 150; i++) begin
      stat_rx_aligned = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0)
        fec_mode_cfg = 2'($urandom_range(0, 3));
      rx_reset = ($urandom_range(0, 39) == 0);
      tick(1);
      rx_reset = 1'b0;
      tick($urandom_range(1, 60));
    end

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
